mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one unified memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the in-order RV32 core. It grants one requester at a time, holds the request until the bus accepts it, waits for the single outstanding response and routes it back to its owner. The IF requester's outstanding fetch is cancelled on a branch redirect.

---
 rtl/rv32_pkg.sv | 31 +++
 rtl/mem_arb_starve_ctr.sv | 32 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the RV32 core memory path: arbiter states, owner tags and
// request/response packets.
package rv32_pkg;

    localparam int RV_ADDR_W = 32;
    localparam int RV_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IMEM,
        OWNER_DMEM
    } mem_owner_t;

    typedef struct packed {
        logic                   we;
        logic [RV_DATA_W/8-1:0] be;
        logic [RV_ADDR_W-1:0]   addr;
        logic [RV_DATA_W-1:0]   wdata;
    } mem_req_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [RV_DATA_W-1:0] data;
    } mem_rsp_packet_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts data grants taken while a fetch waits and
// raises force_imem once STARVE_LIMIT consecutive data grants have been made.
module mem_arb_starve_ctr
    import rv32_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_i,
    input  logic grant_d,
    input  logic imem_req_valid,
    output logic force_imem
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (grant_i || (grant_d && !imem_req_valid)) begin
            cnt <= '0;
        end else if (grant_d && (cnt != CNT_W'(STARVE_LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_imem = (cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the IF and MEM requesters, one transaction in
// flight. Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                imem_req_valid,
    input  logic [ADDR_W-1:0]   imem_req_addr,
    output logic                imem_req_ready,
    output logic                imem_rsp_valid,
    output logic [DATA_W-1:0]   imem_rsp_data,
    input  logic                dmem_req_valid,
    input  logic                dmem_req_we,
    input  logic [DATA_W/8-1:0] dmem_req_be,
    input  logic [ADDR_W-1:0]   dmem_req_addr,
    input  logic [DATA_W-1:0]   dmem_req_wdata,
    output logic                dmem_req_ready,
    output logic                dmem_rsp_valid,
    output logic [DATA_W-1:0]   dmem_rsp_rdata,
    output logic                bus_req_valid,
    output logic                bus_req_we,
    output logic [DATA_W/8-1:0] bus_req_be,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    input  logic                bus_req_ready,
    input  logic                bus_rsp_valid,
    input  logic [DATA_W-1:0]   bus_rsp_rdata,
    input  logic                flush,
    output logic                busy
);

    mem_arb_state_t      state, state_nxt;
    mem_owner_t          owner;
    logic                drop;
    logic                hold_we;
    logic [DATA_W/8-1:0] hold_be;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;
    logic                grant_i, grant_d;
    logic                force_imem;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk           (clk),
        .reset         (reset),
        .grant_i       (grant_i),
        .grant_d       (grant_d),
        .imem_req_valid(imem_req_valid),
        .force_imem    (force_imem)
    );
`else
    logic starve_unused;
    assign starve_unused = (STARVE_LIMIT > 0);
    assign force_imem    = 1'b0;
`endif

    // Data wins by default (MEM holds the older instruction); a flushed fetch is never granted.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (imem_req_valid && !flush && (force_imem || !dmem_req_valid)) begin
                    grant_i = 1'b1;
                end else if (dmem_req_valid) begin
                    grant_d = 1'b1;
                end
                if (grant_i || grant_d) state_nxt = ISSUE;
            end
            ISSUE:   if (bus_req_ready) state_nxt = WAIT;
            WAIT:    if (bus_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= OWNER_IMEM;
            drop           <= 1'b0;
            hold_we        <= 1'b0;
            hold_be        <= '0;
            hold_addr      <= '0;
            hold_wdata     <= '0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            dmem_rsp_valid <= 1'b0;
            dmem_rsp_rdata <= '0;
        end else begin
            state          <= state_nxt;
            imem_rsp_valid <= 1'b0;
            dmem_rsp_valid <= 1'b0;
            if (grant_d) begin
                owner      <= OWNER_DMEM;
                hold_we    <= dmem_req_we;
                hold_be    <= dmem_req_be;
                hold_addr  <= dmem_req_addr;
                hold_wdata <= dmem_req_wdata;
            end else if (grant_i) begin
                owner      <= OWNER_IMEM;
                hold_we    <= 1'b0;
                hold_be    <= '1;
                hold_addr  <= imem_req_addr;
                hold_wdata <= '0;
            end
            // A redirected fetch still finishes on the bus; only its response is swallowed.
            if (state == IDLE) begin
                drop <= 1'b0;
            end else if (flush && (owner == OWNER_IMEM)) begin
                drop <= 1'b1;
            end
            if ((state == WAIT) && bus_rsp_valid) begin
                if (owner == OWNER_DMEM) begin
                    dmem_rsp_valid <= 1'b1;
                    dmem_rsp_rdata <= bus_rsp_rdata;
                end else if (!drop && !flush) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= bus_rsp_rdata;
                end
            end
        end
    end

    assign imem_req_ready = grant_i && !reset;
    assign dmem_req_ready = grant_d && !reset;
    assign bus_req_valid  = (state == ISSUE);
    assign bus_req_we     = hold_we;
    assign bus_req_be     = hold_be;
    assign bus_req_addr   = hold_addr;
    assign bus_req_wdata  = hold_wdata;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued when a
// request is driven and popped when the owner's rsp_valid pulses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid = 1'b0;
    logic [31:0] imem_req_addr = '0;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dmem_req_valid = 1'b0;
    logic        dmem_req_we = 1'b0;
    logic [3:0]  dmem_req_be = '0;
    logic [31:0] dmem_req_addr = '0;
    logic [31:0] dmem_req_wdata = '0;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        bus_req_valid;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_req_ready = 1'b1;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = '0;
    logic        flush = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    // bus model state
    logic        auto_rsp = 1'b1;
    int          rsp_delay = 0;
    logic        hs_seen = 1'b0;
    logic [31:0] hs_addr = '0;
    logic        hs_we = 1'b0;
    int          hs_count = 0;
    logic        pend = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    logic        pend_we = 1'b0;
    int          inj_req = 0;
    int          inj_done = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_we   (dmem_req_we),
        .dmem_req_be   (dmem_req_be),
        .dmem_req_addr (dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_rdata(dmem_rsp_rdata),
        .bus_req_valid (bus_req_valid),
        .bus_req_we    (bus_req_we),
        .bus_req_be    (bus_req_be),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_ready (bus_req_ready),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .flush         (flush),
        .busy          (busy)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // handshake capture and response scoreboard
    always @(negedge clk) begin
        hs_seen = bus_req_valid && bus_req_ready;
        if (hs_seen) begin
            hs_addr = bus_req_addr;
            hs_we   = bus_req_we;
            hs_count++;
        end
        if (dmem_rsp_valid) begin
            if (exp_d.size() == 0) chk("d_rsp_unexp", {31'b0, dmem_rsp_valid}, 32'h0);
            else                   chk("d_rsp_data", dmem_rsp_rdata, exp_d.pop_front());
        end
        if (imem_rsp_valid) begin
            if (exp_i.size() == 0) chk("i_rsp_unexp", {31'b0, imem_rsp_valid}, 32'h0);
            else                   chk("i_rsp_data", imem_rsp_data, exp_i.pop_front());
        end
    end

    // memory: answers each handshake after rsp_delay extra cycles; store acks carry 0
    always @(posedge clk) begin
        #1;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'h0;
        if (hs_seen && auto_rsp) begin
            pend      = 1'b1;
            pend_wait = rsp_delay;
            pend_addr = hs_addr;
            pend_we   = hs_we;
        end
        if (inj_req != inj_done) begin
            inj_done      = inj_req;
            bus_rsp_valid = 1'b1;
            bus_rsp_rdata = 32'hBAD0BAD0;
        end else if (pend) begin
            if (pend_wait == 0) begin
                bus_rsp_valid = 1'b1;
                bus_rsp_rdata = pend_we ? 32'h0 : mem_fn(pend_addr);
                pend          = 1'b0;
            end else begin
                pend_wait--;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || pend) && n < 100);
        chk("idle_timeout", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gcnt;
        int h0;
        string pat;
        logic [7:0] got_seq[10];

        // reset: outputs quiet, ready gated even with a pending request
        dmem_req_valid = 1'b1;
        dmem_req_addr  = 32'h80;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   {31'b0, busy}, 32'h0);
        chk("rst_dready", {31'b0, dmem_req_ready}, 32'h0);
        chk("rst_bvld",   {31'b0, bus_req_valid}, 32'h0);
        chk("rst_baddr",  bus_req_addr, 32'h0);
        chk("rst_bbe",    {28'b0, bus_req_be}, 32'h0);
        chk("rst_drsp",   dmem_rsp_rdata, 32'h0);
        chk("rst_irsp",   imem_rsp_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_req_valid = 1'b0;

        // single load, minimum latency
        @(posedge clk); #1;
        dmem_req_valid = 1'b1; dmem_req_we = 1'b0; dmem_req_addr = 32'h100; dmem_req_be = 4'h0;
        exp_d.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("ld_ready", {31'b0, dmem_req_ready}, 32'h1);
        @(posedge clk); #1 dmem_req_valid = 1'b0;
        @(negedge clk);
        chk("ld_bvld_t1", {31'b0, bus_req_valid}, 32'h1);
        chk("ld_baddr",   bus_req_addr, 32'h100);
        chk("ld_bwe",     {31'b0, bus_req_we}, 32'h0);
        @(negedge clk);
        chk("ld_busy_t2", {31'b0, busy}, 32'h1);
        chk("ld_rsp_t2",  {31'b0, dmem_rsp_valid}, 32'h0);
        @(negedge clk);
        chk("ld_rsp_t3",  {31'b0, dmem_rsp_valid}, 32'h1);
        chk("ld_idle_t3", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("ld_pulse",   {31'b0, dmem_rsp_valid}, 32'h0);
        chk("ld_hold",    dmem_rsp_rdata, 32'hDEADBEEF);

        // simultaneous store and fetch: data first, fetch granted as dmem_rsp pulses
        @(posedge clk); #1;
        dmem_req_valid = 1'b1; dmem_req_we = 1'b1; dmem_req_be = 4'hF;
        dmem_req_addr = 32'h200; dmem_req_wdata = 32'h12345678;
        imem_req_valid = 1'b1; imem_req_addr = 32'h0;
        exp_d.push_back(32'h0);
        exp_i.push_back(mem_fn(32'h0));
        @(negedge clk);
        chk("sim_d_first", {31'b0, dmem_req_ready}, 32'h1);
        chk("sim_i_held",  {31'b0, imem_req_ready}, 32'h0);
        @(posedge clk); #1 dmem_req_valid = 1'b0; dmem_req_we = 1'b0;
        @(negedge clk);
        chk("st_bwe",    {31'b0, bus_req_we}, 32'h1);
        chk("st_bbe",    {28'b0, bus_req_be}, 32'hF);
        chk("st_baddr",  bus_req_addr, 32'h200);
        chk("st_bwdata", bus_req_wdata, 32'h12345678);
        n = 0;
        while (!imem_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sim_i_grant",   {31'b0, imem_req_ready}, 32'h1);
        chk("sim_i_b2b",     {31'b0, dmem_rsp_valid}, 32'h1);
        @(posedge clk); #1 imem_req_valid = 1'b0;
        wait_idle();

        // bus backpressure: five stalled cycles, one handshake
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        dmem_req_valid = 1'b1; dmem_req_we = 1'b1; dmem_req_be = 4'h3;
        dmem_req_addr = 32'h300; dmem_req_wdata = 32'hCAFEF00D;
        exp_d.push_back(32'h0);
        h0 = hs_count;
        @(negedge clk);
        chk("bp_ready", {31'b0, dmem_req_ready}, 32'h1);
        @(posedge clk); #1 dmem_req_valid = 1'b0; dmem_req_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_bvld",  {31'b0, bus_req_valid}, 32'h1);
            chk("bp_baddr", bus_req_addr, 32'h300);
            chk("bp_wdata", bus_req_wdata, 32'hCAFEF00D);
            chk("bp_busy",  {31'b0, busy}, 32'h1);
        end
        @(posedge clk); #1 bus_req_ready = 1'b1;
        wait_idle();
        chk("bp_hs_cnt", hs_count - h0, 32'h1);

        // flush in WAIT on a fetch: response consumed, no imem pulse
        @(posedge clk); #1;
        rsp_delay = 3;
        imem_req_valid = 1'b1; imem_req_addr = 32'h40;
        @(negedge clk);
        chk("fl_grant", {31'b0, imem_req_ready}, 32'h1);
        @(posedge clk); #1 imem_req_valid = 1'b0;
        @(negedge clk);
        chk("fl_issue", {31'b0, bus_req_valid}, 32'h1);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_wait_busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1 flush = 1'b0;
        wait_idle();
        rsp_delay = 0;

        // fetch with flush in IDLE is held off, then served normally
        @(posedge clk); #1;
        imem_req_valid = 1'b1; imem_req_addr = 32'h44; flush = 1'b1;
        @(negedge clk);
        chk("fl_idle_block", {31'b0, imem_req_ready}, 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_i.push_back(mem_fn(32'h44));
        @(negedge clk);
        chk("fl_idle_stay",  {31'b0, busy}, 32'h0);
        chk("fl_idle_grant", {31'b0, imem_req_ready}, 32'h1);
        @(posedge clk); #1 imem_req_valid = 1'b0;
        wait_idle();

        // reset in WAIT, stray bus response afterwards
        @(posedge clk); #1;
        auto_rsp = 1'b0;
        dmem_req_valid = 1'b1; dmem_req_we = 1'b0; dmem_req_be = 4'h0; dmem_req_addr = 32'h500;
        @(negedge clk);
        chk("rw_grant", {31'b0, dmem_req_ready}, 32'h1);
        @(posedge clk); #1 dmem_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rw_in_wait", {31'b0, busy}, 32'h1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        inj_req++;
        @(negedge clk);
        chk("rw_busy",  {31'b0, busy}, 32'h0);
        chk("rw_bvld",  {31'b0, bus_req_valid}, 32'h0);
        chk("rw_baddr", bus_req_addr, 32'h0);
        chk("rw_drsp",  dmem_rsp_rdata, 32'h0);
        @(negedge clk);
        chk("rw_no_rsp", {31'b0, dmem_rsp_valid}, 32'h0);
        chk("rw_still_idle", {31'b0, busy}, 32'h0);
        auto_rsp = 1'b1;

        // both requesters held high: grant order
`ifdef MEM_ARB_STARVE_GUARD_EN
        pat = "DDDDIDDDDI";
`else
        pat = "DDDDDDDDDD";
`endif
        for (int k = 0; k < 10; k++) begin
            got_seq[k] = 8'h2E;
            if (pat[k] == "D") exp_d.push_back(mem_fn(32'h600));
            else               exp_i.push_back(mem_fn(32'h700));
        end
        @(posedge clk); #1;
        dmem_req_valid = 1'b1; dmem_req_we = 1'b0; dmem_req_addr = 32'h600;
        imem_req_valid = 1'b1; imem_req_addr = 32'h700;
        n = 0;
        gcnt = 0;
        while (gcnt < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (dmem_req_ready) begin
                got_seq[gcnt] = "D";
                gcnt++;
            end else if (imem_req_ready) begin
                got_seq[gcnt] = "I";
                gcnt++;
            end
        end
        @(posedge clk); #1;
        dmem_req_valid = 1'b0;
        imem_req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("grant_seq[%0d]", k), {24'b0, got_seq[k]}, {24'b0, pat[k]});
        end
        wait_idle();

        chk("sb_d_empty", exp_d.size(), 32'h0);
        chk("sb_i_empty", exp_i.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
